// File: rtl/id_pkg.sv
// id_pkg: shared definitions for the decode/operand-fetch stage.
//   - Datapath widths (DATA_W, ADDR_W, NUM_REGS, OPC_W).
//   - Instruction field positions: [15:11] opcode, [10:8] rd, [7:5] rs1, [4:2] rs2.
//   - Opcode class encodings (opcode[4:3]) and the decode helper.
//   - FSM state enum (S_DECODE, S_IMM).
package id_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;
  localparam int OPC_W    = 5;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 11;
  localparam int RD_MSB  = 10;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 5;
  localparam int RS2_MSB = 4;
  localparam int RS2_LSB = 2;

  localparam logic [1:0] CLS_LOW  = 2'b00;  // NOP (00000) or two-source ALU
  localparam logic [1:0] CLS_ONE  = 2'b01;  // one-source
  localparam logic [1:0] CLS_IMM  = 2'b10;  // one-source plus immediate word
  localparam logic [1:0] CLS_STBR = 2'b11;  // store/branch

  typedef enum logic {
    S_DECODE = 1'b0,
    S_IMM    = 1'b1
  } state_t;

  typedef struct packed {
    logic uses_rs1;
    logic uses_rs2;
    logic writes_rd;
    logic is_imm;
  } dec_t;

  function automatic dec_t decode_opc(input logic [OPC_W-1:0] opc);
    dec_t d;
    d = '0;
    case (opc[4:3])
      CLS_LOW: begin
        if (opc[2:0] != 3'b000) begin
          d.uses_rs1  = 1'b1;
          d.uses_rs2  = 1'b1;
          d.writes_rd = 1'b1;
        end
      end
      CLS_ONE: begin
        d.uses_rs1  = 1'b1;
        d.writes_rd = 1'b1;
      end
      CLS_IMM: begin
        d.uses_rs1  = 1'b1;
        d.writes_rd = 1'b1;
        d.is_imm    = 1'b1;
      end
      default: begin
        d.uses_rs1 = 1'b1;
        d.uses_rs2 = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/id_scoreboard.sv
// id_scoreboard: one pending-write bit per architectural register.
// Ports:
//   clk, rst             clock, synchronous active-high reset (clears all bits)
//   set_en / set_addr    mark a register pending (instruction issued that writes it)
//   clr_en / clr_addr    writeback retires a register
//   kill_en / kill_addr  a flushed instruction will never write its register
//   rs1, rs2             source registers to look up
//   busy1, busy2         pending bit of rs1 / rs2
// A set and a clear of the same register in one cycle leaves the bit set.
module id_scoreboard
  import id_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              kill_en,
  input  logic [ADDR_W-1:0] kill_addr,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  output logic              busy1,
  output logic              busy2
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  always_comb begin
    busy_d = busy_q;
    if (clr_en)  busy_d[clr_addr]  = 1'b0;
    if (kill_en) busy_d[kill_addr] = 1'b0;
    // Applied last so a same-cycle set beats either clear.
    if (set_en)  busy_d[set_addr]  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) busy_q <= '0;
    else     busy_q <= busy_d;
  end

  assign busy1 = busy_q[rs1];
  assign busy2 = busy_q[rs2];

endmodule

// File: rtl/id_operand_stage.sv
// id_operand_stage: decode / operand-fetch stage of the 16-bit, 8-register core.
// Accepts fetch words over if_valid/if_ready, reads the register file
// asynchronously, stalls on RAW hazards tracked by id_scoreboard, assembles
// two-word immediate instructions and issues into the ID/EX register (ex_*).
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   if_valid, if_instr, if_ready fetch handshake
//   rf_read_addr1/2              register file read addresses (combinational)
//   rf_read_data1/2              register file read data (combinational)
//   wb_write_enable/addr/data    writeback port (data used only with bypass)
//   flush                        discard held instruction and latched header
//   ex_ready, ex_valid           execute handshake
//   ex_opcode, ex_rd, ex_op1, ex_op2, ex_imm, ex_writes_rd   ID/EX payload
// Build option: define ID_WB_BYPASS_EN to forward a same-cycle writeback into
// the operand instead of waiting for the scoreboard bit to clear.
module id_operand_stage
  import id_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              if_valid,
  input  logic [DATA_W-1:0] if_instr,
  output logic              if_ready,
  output logic [ADDR_W-1:0] rf_read_addr1,
  output logic [ADDR_W-1:0] rf_read_addr2,
  input  logic [DATA_W-1:0] rf_read_data1,
  input  logic [DATA_W-1:0] rf_read_data2,
  input  logic              wb_write_enable,
  input  logic [ADDR_W-1:0] wb_write_addr,
  input  logic [DATA_W-1:0] wb_write_data,
  input  logic              flush,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [OPC_W-1:0]  ex_opcode,
  output logic [ADDR_W-1:0] ex_rd,
  output logic [DATA_W-1:0] ex_op1,
  output logic [DATA_W-1:0] ex_op2,
  output logic [DATA_W-1:0] ex_imm,
  output logic              ex_writes_rd
);

  state_t                state_q;
  logic [DATA_W-1:2]     hdr_p0;
  logic [DATA_W-1:2]     cur_hdr;
  logic [OPC_W-1:0]      cur_opc;
  logic [ADDR_W-1:0]     cur_rd;
  logic [ADDR_W-1:0]     cur_rs1;
  logic [ADDR_W-1:0]     cur_rs2;
  dec_t                  dec;
  logic                  busy1;
  logic                  busy2;
  logic                  byp1;
  logic                  byp2;
  logic                  hazard;
  logic                  slot_free;
  logic                  hdr_only;
  logic                  hs;
  logic                  issue;
  logic                  kill_en;
  logic [DATA_W-1:0]     src1_p0;
  logic [DATA_W-1:0]     src2_p0;

  logic                  vld_p1;
  logic [OPC_W-1:0]      opc_p1;
  logic [ADDR_W-1:0]     rd_p1;
  logic [DATA_W-1:0]     op1_p1;
  logic [DATA_W-1:0]     op2_p1;
  logic [DATA_W-1:0]     imm_p1;
  logic                  wr_p1;

  // ---- Stage p0: decode of the current header and hazard check ----
  // While waiting for the immediate word, the latched header drives decode.
  assign cur_hdr = (state_q == S_IMM) ? hdr_p0 : if_instr[DATA_W-1:2];
  assign cur_opc = cur_hdr[OPC_MSB:OPC_LSB];
  assign cur_rd  = cur_hdr[RD_MSB:RD_LSB];
  assign cur_rs1 = cur_hdr[RS1_MSB:RS1_LSB];
  assign cur_rs2 = cur_hdr[RS2_MSB:RS2_LSB];
  assign dec     = decode_opc(cur_opc);

  assign rf_read_addr1 = cur_rs1;
  assign rf_read_addr2 = cur_rs2;

`ifdef ID_WB_BYPASS_EN
  assign byp1    = wb_write_enable && (wb_write_addr == cur_rs1);
  assign byp2    = wb_write_enable && (wb_write_addr == cur_rs2);
  assign src1_p0 = byp1 ? wb_write_data : rf_read_data1;
  assign src2_p0 = byp2 ? wb_write_data : rf_read_data2;
`else
  logic unused_wb_data;
  assign unused_wb_data = ^wb_write_data;
  assign byp1    = 1'b0;
  assign byp2    = 1'b0;
  assign src1_p0 = rf_read_data1;
  assign src2_p0 = rf_read_data2;
`endif

  id_scoreboard u_sb (
    .clk       (clk),
    .rst       (rst),
    .set_en    (issue && dec.writes_rd),
    .set_addr  (cur_rd),
    .clr_en    (wb_write_enable),
    .clr_addr  (wb_write_addr),
    .kill_en   (kill_en),
    .kill_addr (rd_p1),
    .rs1       (cur_rs1),
    .rs2       (cur_rs2),
    .busy1     (busy1),
    .busy2     (busy2)
  );

  assign hazard    = (dec.uses_rs1 && busy1 && !byp1) ||
                     (dec.uses_rs2 && busy2 && !byp2);
  assign slot_free = !vld_p1 || ex_ready;
  // An immediate header only gets latched; its sources are checked when the
  // immediate word arrives and the instruction actually issues.
  assign hdr_only  = (state_q == S_DECODE) && dec.is_imm;
  assign if_ready  = !rst && slot_free && !flush && (!hazard || hdr_only);
  assign hs        = if_valid && if_ready;
  assign issue     = hs && !hdr_only;
  // A held instruction that EX is taking this cycle still reaches writeback,
  // so only an instruction that is really dropped releases its register.
  assign kill_en   = flush && vld_p1 && !ex_ready && wr_p1;

  // ---- Stage p1: ID/EX register and FSM ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_DECODE;
      hdr_p0  <= '0;
      vld_p1  <= 1'b0;
      opc_p1  <= '0;
      rd_p1   <= '0;
      op1_p1  <= '0;
      op2_p1  <= '0;
      imm_p1  <= '0;
      wr_p1   <= 1'b0;
    end else if (flush) begin
      state_q <= S_DECODE;
      vld_p1  <= 1'b0;
    end else begin
      if (hs) begin
        if (hdr_only) begin
          state_q <= S_IMM;
          hdr_p0  <= if_instr[DATA_W-1:2];
        end else begin
          state_q <= S_DECODE;
        end
      end
      if (issue) begin
        vld_p1 <= 1'b1;
        opc_p1 <= cur_opc;
        rd_p1  <= cur_rd;
        op1_p1 <= dec.uses_rs1 ? src1_p0 : '0;
        op2_p1 <= dec.uses_rs2 ? src2_p0 : '0;
        imm_p1 <= (state_q == S_IMM) ? if_instr : '0;
        wr_p1  <= dec.writes_rd;
      end else if (ex_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign ex_valid     = vld_p1;
  assign ex_opcode    = opc_p1;
  assign ex_rd        = rd_p1;
  assign ex_op1       = op1_p1;
  assign ex_op2       = op2_p1;
  assign ex_imm       = imm_p1;
  assign ex_writes_rd = wr_p1;

endmodule
